// File: rtl/bcd_convert.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with sign handling.
// Latency: WIDTH+1 clocks from accepted start to done pulse with updated digits.
// Backpressure: start is ignored while busy; a held start re-triggers every WIDTH+2 clocks.
module bcd_convert #(
   parameter int WIDTH = 8   // legal 4..13 so the magnitude never exceeds 9999
) (
   input  logic             clk,
   input  logic             rst,          // asynchronous, active-low
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] value,
   output logic             busy,
   output logic             done,
   output logic             sinal,
   output logic [3:0]       d0,
   output logic [3:0]       d1,
   output logic [3:0]       d2,
   output logic [3:0]       d3
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state_q,  state_d;
   logic             neg_q,    neg_d;      // sign latched at start
   logic             mag_nz_q, mag_nz_d;   // original magnitude was non-zero
   logic [WIDTH-1:0] mag_q,    mag_d;      // magnitude shift register
   logic [15:0]      acc_q,    acc_d;      // four-digit BCD accumulator
   logic [CW-1:0]    cnt_q,    cnt_d;      // bits still to shift in
   logic [15:0]      dig_q,    dig_d;      // displayed digits {d3,d2,d1,d0}
   logic             sinal_q,  sinal_d;
   logic             done_q,   done_d;

   logic [15:0]      acc_adj;
   logic             start_neg;

   // Add-3 correction: any nibble of 5 or more would exceed 9 after the doubling shift.
   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < 4; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
   end

   assign start_neg = signed_mode & value[WIDTH-1];

   // Next-state logic for the IDLE -> SHIFT -> DONE sequence and all datapath registers.
   always_comb begin
      state_d  = state_q;
      neg_d    = neg_q;
      mag_nz_d = mag_nz_q;
      mag_d    = mag_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      dig_d    = dig_q;
      sinal_d  = sinal_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_SHIFT;
               neg_d    = start_neg;
               // -2^(WIDTH-1) negates to 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
               mag_d    = start_neg ? (~value + WIDTH'(1)) : value;
               mag_nz_d = |value;
               acc_d    = '0;
               cnt_d    = CW'(WIDTH);
            end
         end

         S_SHIFT: begin
            // {acc, mag} shifts left as one register; mag's MSB feeds the units digit.
            acc_d = {acc_adj[14:0], mag_q[WIDTH-1]};
            mag_d = {mag_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            dig_d   = acc_q;
            // Negative zero cannot arise from two's complement, but never show "-0".
            sinal_d = neg_q & mag_nz_q;
            done_d  = 1'b1;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any conversion and clears the display.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         neg_q    <= 1'b0;
         mag_nz_q <= 1'b0;
         mag_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         dig_q    <= '0;
         sinal_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         neg_q    <= neg_d;
         mag_nz_q <= mag_nz_d;
         mag_q    <= mag_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         dig_q    <= dig_d;
         sinal_q  <= sinal_d;
         done_q   <= done_d;
      end
   end

   // busy drops on the same edge that publishes the result, so the done cycle is already IDLE.
   assign busy  = (state_q != S_IDLE);
   assign done  = done_q;
   assign sinal = sinal_q;
   assign d0    = dig_q[3:0];
   assign d1    = dig_q[7:4];
   assign d2    = dig_q[11:8];
   assign d3    = dig_q[15:12];

endmodule

// File: tb/tb_bcd_convert.sv
// Bench for bcd_convert: reference model uses integer arithmetic (abs, /10, %10).
// Timing checked cycle by cycle: busy after edges k..k+WIDTH, done exactly after k+WIDTH+1.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_bcd_convert;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         signed_mode = 1'b0;
   logic [W-1:0] value = '0;
   logic         busy, done, sinal;
   logic [3:0]   d0, d1, d2, d3;

   int total = 0;
   int bad   = 0;

   bcd_convert #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .value(value),
      .busy(busy), .done(done), .sinal(sinal),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3)
   );

   always #5 clk = ~clk;

   // Expected {sinal, d3, d2, d1, d0} from plain decimal arithmetic.
   function automatic logic [16:0] model(input logic sm, input logic [W-1:0] v);
      int x, mag;
      logic neg;
      if (sm) x = int'($signed(v));
      else    x = int'(v);
      neg = (x < 0);
      mag = neg ? -x : x;
      return {neg && (mag != 0),
              4'((mag / 1000) % 10), 4'((mag / 100) % 10),
              4'((mag / 10) % 10),   4'(mag % 10)};
   endfunction

   function automatic logic [16:0] observed();
      return {sinal, d3, d2, d1, d0};
   endfunction

   // One conversion from the current (post-edge) time; returns after edge k+W+1.
   task automatic run_conv(input logic sm, input logic [W-1:0] v,
                           input bit abuse, input bit hold, input string tag);
      logic [16:0] exp;
      exp = model(sm, v);
      start = 1'b1; signed_mode = sm; value = v;
      @(posedge clk); #1;                       // edge k
      if (!hold) start = 1'b0;
      value = W'($urandom); signed_mode = 1'($urandom);
      for (int c = 0; c <= W; c++) begin
         total++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s busy/done after edge k+%0d: got busy=%b done=%b, want busy=1 done=0",
                     tag, c, busy, done);
         end
         if (abuse && c == 2) begin start = 1'b1; value = ~v; signed_mode = ~sm; end
         if (abuse && c == 3) start = 1'b0;
         @(posedge clk); #1;
      end
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || observed() !== exp) begin
         bad++;
         $display("FAIL %s result sm=%b v=%h: got done=%b busy=%b out=%h, want done=1 busy=0 out=%h",
                  tag, sm, v, done, busy, observed(), exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({busy, done, observed()} !== 19'd0) begin
         bad++;
         $display("FAIL reset_state: got %h, want 0", {busy, done, observed()});
      end
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         total++;
         if ({busy, done, observed()} !== 19'd0) begin
            bad++;
            $display("FAIL idle_after_reset cycle %0d: got %h, want 0", i, {busy, done, observed()});
         end
      end
   endtask

   task automatic test_signed_min();
      run_conv(1'b1, 8'h80, 1'b0, 1'b0, "signed_min");
      total++;
      if (observed() !== {1'b1, 16'h0128}) begin
         bad++;
         $display("FAIL signed_min_digits: got %h, want %h", observed(), {1'b1, 16'h0128});
      end
   endtask

   task automatic test_all_ones();
      run_conv(1'b0, 8'hFF, 1'b0, 1'b0, "ones_unsigned");
      total++;
      if (observed() !== {1'b0, 16'h0255}) begin
         bad++;
         $display("FAIL ones_unsigned_digits: got %h, want %h", observed(), {1'b0, 16'h0255});
      end
      run_conv(1'b1, 8'hFF, 1'b0, 1'b0, "ones_signed");
      total++;
      if (observed() !== {1'b1, 16'h0001}) begin
         bad++;
         $display("FAIL ones_signed_digits: got %h, want %h", observed(), {1'b1, 16'h0001});
      end
      // Outputs must hold between conversions with no further done pulse.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++;
         if (done !== 1'b0 || busy !== 1'b0 || observed() !== {1'b1, 16'h0001}) begin
            bad++;
            $display("FAIL hold_outputs cycle %0d: got done=%b busy=%b out=%h, want 0 0 %h",
                     i, done, busy, observed(), {1'b1, 16'h0001});
         end
      end
   endtask

   task automatic test_sweep();
      for (int m = 0; m < 2; m++) begin
         for (int v = 0; v < 256; v++) begin
            run_conv(1'(m), W'(v), 1'b0, 1'b0, "sweep");
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 100; i++) begin
         run_conv(1'($urandom), W'($urandom), 1'b0, 1'b0, "random");
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
   endtask

   task automatic test_busy_abuse();
      run_conv(1'b0, 8'd37, 1'b1, 1'b0, "busy_abuse");
      run_conv(1'b1, 8'hC3, 1'b1, 1'b0, "busy_abuse_signed");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         run_conv(1'($urandom), W'($urandom), 1'b0, 1'b1, "back_to_back");
      end
      start = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      run_conv(1'b0, 8'd199, 1'b0, 1'b0, "pre_reset");
      start = 1'b1; signed_mode = 1'b0; value = 8'd99;
      @(posedge clk); #1;                       // edge k
      start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      total++;
      if ({busy, done, observed()} !== 19'd0) begin
         bad++;
         $display("FAIL reset_mid_immediate: got %h, want 0", {busy, done, observed()});
      end
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         total++;
         if ({busy, done, observed()} !== 19'd0) begin
            bad++;
            $display("FAIL reset_mid_hold cycle %0d: got %h, want 0", i, {busy, done, observed()});
         end
      end
      rst = 1'b1;
      run_conv(1'b0, 8'd42, 1'b0, 1'b0, "after_reset");
      total++;
      if (observed() !== {1'b0, 16'h0042}) begin
         bad++;
         $display("FAIL after_reset_digits: got %h, want %h", observed(), {1'b0, 16'h0042});
      end
   endtask

   initial begin
      test_reset();
      test_signed_min();
      test_all_ones();
      test_sweep();
      test_random();
      test_busy_abuse();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
